// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op codes and default widths.
// The SHIFT_ARB_ROTATE_EN macro (see shift_unit) gives OP_ROR its rotate meaning;
// without it the code is executed as a logical right shift.
package shift_pkg;

    localparam int SHIFT_WIDTH   = 32;
    localparam int SHIFT_SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

endpackage

// File: rtl/shift_unit.sv
// Combinational log-stage barrel shifter. One 2:1 mux stage per shamt bit,
// largest stage first (16/8/4/2/1 for a 32-bit datapath).
// Optional: SHIFT_ARB_ROTATE_EN makes op 11 a rotate right; otherwise op 11
// falls through to the logical right shift and no rotate muxing exists.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH,
    parameter int SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   result
);

    // stg[SHAMT_W] is the raw operand; stg[0] is the fully shifted value
    logic [SHAMT_W:0][WIDTH-1:0] stg;

    assign stg[SHAMT_W] = data;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] shifted;

        assign src = stg[i+1];

        // shift src by the fixed stage amount in the direction/fill the op asks for
        always_comb begin
            shifted = {{SH{1'b0}}, src[WIDTH-1:SH]};
            case (op)
                OP_SLL:  shifted = {src[WIDTH-SH-1:0], {SH{1'b0}}};
                OP_SRA:  shifted = {{SH{src[WIDTH-1]}}, src[WIDTH-1:SH]};
`ifdef SHIFT_ARB_ROTATE_EN
                OP_ROR:  shifted = {src[SH-1:0], src[WIDTH-1:SH]};
`endif
                default: shifted = {{SH{1'b0}}, src[WIDTH-1:SH]};
            endcase
        end

        assign stg[i] = shamt[i] ? shifted : src;
    end

    assign result = stg[0];

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one barrel shifter. Each port has a one-entry slot;
// a round-robin pointer picks one full slot per cycle and the shifted result
// is registered back to its owner with a single-cycle valid pulse.
// Optional: SHIFT_ARB_ROTATE_EN enables rotate-right for op 11 in shift_unit.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH,
    parameter int SHAMT_W = SHIFT_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [1:0]         req0_op,
    output logic               res0_valid,
    output logic [WIDTH-1:0]   res0_data,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req1_op,
    output logic               res1_valid,
    output logic [WIDTH-1:0]   res1_data,

    output logic               gnt_id
);

    logic               slot0_full, slot1_full;
    logic [WIDTH-1:0]   slot0_data, slot1_data;
    logic [SHAMT_W-1:0] slot0_shamt, slot1_shamt;
    logic [1:0]         slot0_op, slot1_op;

    // id of the most recently served port; the other port wins a tie
    logic               rr_last;

    logic               grant_any;
    logic               grant_id;
    logic [WIDTH-1:0]   sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [1:0]         sel_op;
    logic [WIDTH-1:0]   shift_out;

    // ready comes straight from the slot flag, so there is no valid->ready path
    assign req0_ready = ~slot0_full;
    assign req1_ready = ~slot1_full;

    // pick the slot to serve this cycle and steer it onto the shared shifter
    always_comb begin
        grant_any = slot0_full | slot1_full;
        grant_id  = (slot0_full & slot1_full) ? ~rr_last : slot1_full;
        sel_data  = grant_id ? slot1_data  : slot0_data;
        sel_shamt = grant_id ? slot1_shamt : slot0_shamt;
        sel_op    = grant_id ? slot1_op    : slot0_op;
    end

    assign gnt_id = grant_id;

    shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .data   (sel_data),
        .shamt  (sel_shamt),
        .op     (sel_op),
        .result (shift_out)
    );

    // holding slots: capture on handshake, free on the edge that serves them
    always_ff @(posedge clock) begin
        if (reset) begin
            slot0_full <= 1'b0;
            slot1_full <= 1'b0;
        end else begin
            if (grant_any && !grant_id) begin
                slot0_full <= 1'b0;
            end else if (req0_valid && !slot0_full) begin
                slot0_full  <= 1'b1;
                slot0_data  <= req0_data;
                slot0_shamt <= req0_shamt;
                slot0_op    <= req0_op;
            end

            if (grant_any && grant_id) begin
                slot1_full <= 1'b0;
            end else if (req1_valid && !slot1_full) begin
                slot1_full  <= 1'b1;
                slot1_data  <= req1_data;
                slot1_shamt <= req1_shamt;
                slot1_op    <= req1_op;
            end
        end
    end

    // result registers, valid pulses and round-robin pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_data  <= '0;
            res1_data  <= '0;
            rr_last    <= 1'b1;
        end else begin
            res0_valid <= grant_any & ~grant_id;
            res1_valid <= grant_any &  grant_id;
            if (grant_any && !grant_id) begin
                res0_data <= shift_out;
            end
            if (grant_any && grant_id) begin
                res1_data <= shift_out;
            end
            if (grant_any) begin
                rr_last <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a per-port scoreboard of expected
// results and latency windows.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_ready, res0_valid;
    logic [31:0] req0_data, res0_data;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready, res1_valid;
    logic [31:0] req1_data, res1_data;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_op;
    logic        gnt_id;

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .res0_valid (res0_valid),
        .res0_data  (res0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .res1_valid (res1_valid),
        .res1_data  (res1_data),
        .gnt_id     (gnt_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lmin;
        int          lmax;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic [1:0] op);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = d << s;
            OP_SRA:  r = $unsigned($signed(d) >>> s);
            OP_SRL:  r = d >> s;
`ifdef SHIFT_ARB_ROTATE_EN
            default: r = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
`else
            default: r = d >> s;
`endif
        endcase
        return r;
    endfunction

    // compare each result pulse against the head of its port's queue
    always @(negedge clock) begin
        exp_t e;
        int   lat;
        if (res0_valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("res0_unexpected", 32'd1, 32'd0);
            end else begin
                e   = q0.pop_front();
                lat = cyc - e.acc;
                check("res0_data", res0_data, e.data);
                check("res0_latency", 32'(lat), (lat >= e.lmin && lat <= e.lmax) ? 32'(lat) : 32'(e.lmin));
            end
        end
        if (res1_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("res1_unexpected", 32'd1, 32'd0);
            end else begin
                e   = q1.pop_front();
                lat = cyc - e.acc;
                check("res1_data", res1_data, e.data);
                check("res1_latency", 32'(lat), (lat >= e.lmin && lat <= e.lmax) ? 32'(lat) : 32'(e.lmin));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // present a request on a port this cycle; optionally record the expected result
    task automatic send(input int port, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp,
                        input int lmin, input int lmax, input bit track);
        exp_t e;
        e.data = exp;
        e.acc  = cyc;
        e.lmin = lmin;
        e.lmax = lmax;
        if (port == 0) begin
            check("req0_ready_before_send", 32'(req0_ready), 32'd1);
            req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
            if (track) q0.push_back(e);
        end else begin
            check("req1_ready_before_send", 32'(req1_ready), 32'd1);
            req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
            if (track) q1.push_back(e);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  op;
        logic        prev0;
        logic [31:0] rot_exp;

        reset = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = '0;
        req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_req0_ready", 32'(req0_ready), 32'd1);
        check("rst_req1_ready", 32'(req1_ready), 32'd1);
        check("rst_res0_valid", 32'(res0_valid), 32'd0);
        check("rst_res1_valid", 32'(res1_valid), 32'd0);
        check("rst_res0_data", res0_data, 32'd0);
        check("rst_res1_data", res1_data, 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);

        // reset while slot0 holds an operation: it must vanish
        send(0, 32'hDEAD_BEEF, 5'd3, OP_SLL, 32'd0, 0, 0, 1'b0);
        step();
        idle();
        check("midrst_slot_full", 32'(req0_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("midrst_no_res0", 32'(res0_valid), 32'd0);
            check("midrst_res0_data", res0_data, 32'd0);
            check("midrst_ready0", 32'(req0_ready), 32'd1);
            step();
        end

        // single-port directed vectors, uncontended latency 2
        send(0, 32'h8000_0000, 5'd4, OP_SRA, 32'hF800_0000, 2, 2, 1'b1);
        step(); idle(); drain();
        send(0, 32'h8000_0000, 5'd4, OP_SRL, 32'h0800_0000, 2, 2, 1'b1);
        step(); idle(); drain();
        send(1, 32'h0000_0001, 5'd31, OP_SLL, 32'h8000_0000, 2, 2, 1'b1);
        step(); idle(); drain();
        send(1, 32'h1234_5678, 5'd0, OP_SLL, 32'h1234_5678, 2, 2, 1'b1);
        step(); idle(); drain();

        // simultaneous accept right after reset: port 0 first, port 1 one cycle later
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        send(0, 32'h0000_00F0, 5'd4, OP_SRL, 32'h0000_000F, 2, 2, 1'b1);
        send(1, 32'hF000_0000, 5'd8, OP_SRA, 32'hFFF0_0000, 3, 3, 1'b1);
        step(); idle();
        check("tie_gnt_first", 32'(gnt_id), 32'd0);
        step();
        check("tie_gnt_second", 32'(gnt_id), 32'd1);
        drain();

        // reserved op 11
`ifdef SHIFT_ARB_ROTATE_EN
        rot_exp = 32'hF000_0000;
`else
        rot_exp = 32'h0000_0000;
`endif
        send(0, 32'h0000_000F, 5'd4, OP_ROR, rot_exp, 2, 2, 1'b1);
        step(); idle(); drain();

        // rr_last is now 0, so port 1 wins the tie and slot0 stays full for two cycles
        send(0, 32'hA5A5_0000, 5'd16, OP_SRL, 32'h0000_A5A5, 3, 3, 1'b1);
        send(1, 32'h0000_0003, 5'd1, OP_SLL, 32'h0000_0006, 2, 2, 1'b1);
        step();
        req1_valid = 1'b0;
        check("hold_gnt_port1", 32'(gnt_id), 32'd1);
        check("hold_ready0_a", 32'(req0_ready), 32'd0);
        req0_data = 32'h1111_1111; req0_shamt = 5'd2; req0_op = OP_SLL;
        step();
        check("hold_ready0_b", 32'(req0_ready), 32'd0);
        req0_data = 32'h2222_2222;
        step();
        check("hold_ready0_free", 32'(req0_ready), 32'd1);
        idle();
        drain();

        // sustained contention with random operands: results alternate every cycle
        prev0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 2) begin
                check("cont_one_result", 32'(res0_valid ^ res1_valid), 32'd1);
            end
            if (i >= 3) begin
                check("cont_alternate", 32'(res1_valid), 32'(prev0));
            end
            prev0 = res0_valid;
            idle();
            if (req0_ready) begin
                d = $urandom(); s = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
                send(0, d, s, op, model(d, s, op), 2, 3, 1'b1);
            end
            if (req1_ready) begin
                d = $urandom(); s = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
                send(1, d, s, op, model(d, s, op), 2, 3, 1'b1);
            end
            step();
        end
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter between two requesters, e.g. the ALU shift path (port 0) and the multdiv/serial-control path (port 1).
- Each requester owns a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter issues one slot per cycle to the shared shifter; the result is registered and returned to the owner with a one-cycle valid pulse.

Parameters:
- WIDTH, 32, data width of operands and results.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  slot 0 empty; request accepted when valid&ready.
- req0_data  input  WIDTH  operand.
- req0_shamt  input  SHAMT_W  shift amount.
- req0_op  input  2  operation code.
- res0_valid  output  1  one-cycle pulse; res0_data is valid.
- res0_data  output  WIDTH  registered result for requester 0.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op, res1_valid, res1_data: identical to port 0, for requester 1.
- gnt_id  output  1  id of the slot granted in the current cycle (debug); meaningful only when some slot is full.

Behaviour:
- Op codes: 00 SLL, 01 SRA (sign-fill), 10 SRL (zero-fill), 11 reserved (see Optional Feature).
- Shift amount 0 returns the operand unchanged. Amounts are taken modulo WIDTH by width; there is no saturation.
- Reset (synchronous, dominates everything):
  - slot0_full = slot1_full = 0.
  - res0_valid = res1_valid = 0.
  - res0_data = res1_data = 0.
  - rr_last = 1, so port 0 wins the first contention.
  - gnt_id = 0.
- Reset mid-operation discards held slots and any pending result; no res_valid pulse follows.
- reqN_ready = ~slotN_full. It is a registered term with no combinational path from valid.
- Accept: on valid&ready at an edge, the slot captures {data, shamt, op} and slotN_full becomes 1.
- Grant, each cycle:
  - Only slot0 full -> grant 0. Only slot1 full -> grant 1.
  - Both full -> grant the id != rr_last.
  - No slot full -> no grant, and rr_last holds.
- On a grant:
  - The granted slot drives the shared shifter.
  - At the edge: resN_data <= shifter output, resN_valid <= 1, slotN_full <= 0, rr_last <= granted id.
  - Non-granted resM_valid <= 0. resM_data holds its last value.
- Latency: accept edge -> grant cycle -> result edge. resN_valid rises 2 cycles after the accepting edge when uncontended, 3 cycles when it loses one arbitration.
- Throughput:
  - One result per cycle in aggregate.
  - One accept per 2 cycles per port, because the slot frees at the grant edge and ready rises the following cycle.
- Simultaneous accept on both ports in the same cycle is legal. Both are served in the next two cycles in rr order.
- Starvation-free: under continuous contention the ports alternate strictly.
- res_valid is a pulse with no back-pressure. The consumer must capture it in that cycle.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined: op 11 = rotate right by shamt (bits shifted out at bit 0 re-enter at bit WIDTH-1).
- Undefined: op 11 is executed as SRL. No rotate logic is synthesised.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package shift_pkg holds:
  - op-code localparams OP_SLL=2'b00, OP_SRA=2'b01, OP_SRL=2'b10, OP_ROR=2'b11;
  - WIDTH/SHAMT_W defaults.
- One sub-module, shift_unit: purely combinational log-stage barrel shifter (16/8/4/2/1 stages selected by shamt bits through 2:1 muxes), with inputs data, shamt and op.
- shift_arbiter instantiates exactly one shift_unit and contains the slots, the rr pointer and the result registers.

Test Plan:
- Reset held 2 cycles, then released -> both ready=1, res_valid=0, res_data=0; a reset pulse while slot0 is full -> slot dropped, no res0_valid afterwards.
- Port 0 only: data=0x80000000, shamt=4, op SRA -> res0_valid pulses 2 cycles after accept, res0_data=0xF8000000; the same operation with op SRL -> 0x08000000.
- Port 1 SLL: data=0x00000001, shamt=31 -> 0x80000000; data=0x12345678, shamt=0 -> 0x12345678.
- Both ports accept in the same cycle after reset -> res0_valid first, res1_valid the next cycle; repeated back-to-back contention -> strict alternation, with each port never waiting more than 1 extra cycle.
- Ready behaviour: with a slot full, req0_valid held high -> req0_ready=0 until the cycle after the grant; no second capture occurs, and data changes while not ready are ignored.
- Op 11: data=0x0000000F, shamt=4 -> 0xF0000000 with SHIFT_ARB_ROTATE_EN defined, 0x00000000 without it.
